module_requester: RTL and testbench
===================================

// Module: module_requester
// PURPOSE
// - Requester-side agent for one module port (M1, M2 or M3) of the shared-resource controller.
// - Converts a local job (start + beat count) into the controller's req/done handshake.
// - Watches accmodule for grant and runs the job's beats; resumes after preemption.
// - Flags starvation; one instance per module sits beside the controller in the system top.
// PARAMETERS
// - MOD_ID      0     module index: 0=M1, 1=M2, 2=M3; drives bit MOD_ID of the controller req/done
// - LENW        8     width of job_len and of the remaining-beat counter
// - WAIT_LIMIT  64    cycles in S_REQ without grant before starved sets (1..2^16-1)
// - CNTW        8     width of preempt_cnt
// PORTS
// - clk          in   1     system clock, rising edge
// - reset        in   1     asynchronous, active-high reset
// - start        in   1     job request; accepted when start && start_ready
// - job_len      in   LENW  beats for the job, sampled with start; 0 is treated as 1
// - start_ready  out   1     low only when both the active and the pending job slots are full
// - accmodule    in   2     controller grant: 0=none, 1=M1, 2=M2, 3=M3
// - req          out   1     request to controller (bit MOD_ID of controller req)
// - done         out   1     one-cycle end-of-access pulse (bit MOD_ID of controller done)
// - busy         out   1     high in any state other than S_IDLE
// - granted      out   1     high when accmodule == MOD_ID+1 while in S_XFER
// - job_done     out   1     one-cycle pulse, coincident with done
// - preempt_cnt  out   CNTW  saturating count of grants lost mid-job
// - starved      out   1     sticky; cleared only by reset
// BEHAVIOUR
// - Reset (async, immediate): all outputs 0 except start_ready=1; state S_IDLE; both job slots empty; counters 0.
// - Reset asserted mid-job aborts the job silently, with no done pulse.
// - Grant condition: g = (accmodule == MOD_ID+1).
// - FSM states: S_IDLE, S_REQ, S_XFER, S_DONE. All outputs are registered.
//   - S_IDLE: an accepted start loads rem=max(job_len,1) and moves to S_REQ; req is high the next cycle (1-cycle latency).
//   - S_REQ: req=1. When g, move to S_XFER. wait_cnt increments each cycle without g; at WAIT_LIMIT, starved<=1. wait_cnt clears on g.
//   - S_XFER: req=1. Each cycle with g, rem decrements. When rem==1 and g, move to S_DONE.
//   - Preemption in S_XFER: !g with rem>1 returns to S_REQ with rem preserved, and preempt_cnt increments, saturating at all-ones.
//   - S_DONE: req=0, done=1, job_done=1 for exactly one cycle. Then S_REQ if the pending slot is valid (pending promoted, rem reloaded), else S_IDLE.
// - Job buffer: one active slot plus one pending slot.
//   - start while busy fills the pending slot. start_ready = !(busy && pending_valid).
//   - start with start_ready low is ignored; no error is raised.
// - Simultaneous start in the S_DONE cycle: the job is captured into pending, or promoted directly if pending is empty.
// - A start accepted in S_IDLE is never lost.
// - req never drops between S_REQ and S_XFER. req and done are never both high.
// - M1 (MOD_ID=0) is never preempted by design; the preempt logic stays generic.
// STRUCTURE
// - ctrl_pkg holds the MOD_M1/M2/M3 indices, ACC_NONE/ACC_M1/ACC_M2/ACC_M3 encodings, and the req_state_t enum.
// - Sub-module sat_counter #(W) (inc, clr, saturating) is used for wait_cnt and preempt_cnt.
// - Job slots, FSM and output registers live in this module.
// TESTING
// - Reset then idle: req=0, done=0, start_ready=1, preempt_cnt=0, starved=0.
// - MOD_ID=1, start job_len=3, accmodule=2 held: req rises 1 cycle later; 3 granted cycles; done pulse; req=0 in the done cycle.
// - MOD_ID=1, job_len=4: grant 2 cycles, accmodule=1 for 3 cycles, grant again.
//   Expect return to req, preempt_cnt=1, 2 more beats, then done.
// - Back-to-back jobs: start twice while busy, third start sees start_ready=0 and is ignored; exactly 2 done pulses.
// - WAIT_LIMIT=4, accmodule=0 held: starved=1 after 4 cycles; stays 1 after a later grant.
// - Reset asserted mid-S_XFER: req=0 immediately, no done pulse, start_ready=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the resource controller and its requester agents:
// module indices, accmodule grant codes and the requester FSM states.
package ctrl_pkg;

  localparam int MOD_M1 = 0;
  localparam int MOD_M2 = 1;
  localparam int MOD_M3 = 2;

  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_M1   = 2'd1;
  localparam logic [1:0] ACC_M2   = 2'd2;
  localparam logic [1:0] ACC_M3   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } req_state_t;

  // accmodule value that grants the given module index
  function automatic logic [1:0] acc_code(input int mod_id);
    return 2'(mod_id + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // count up until all-ones, then hold
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/module_requester.sv
// Requester agent for one controller port: turns a local job into the req/done
// handshake, runs beats while granted, resumes after preemption, flags starvation.
module module_requester
  import ctrl_pkg::*;
#(
  parameter int MOD_ID     = 0,
  parameter int LENW       = 8,
  parameter int WAIT_LIMIT = 64,
  parameter int CNTW       = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [LENW-1:0] i_job_len,
  output logic            o_start_ready,
  input  logic [1:0]      i_accmodule,
  output logic            o_req,
  output logic            o_done,
  output logic            o_busy,
  output logic            o_granted,
  output logic            o_job_done,
  output logic [CNTW-1:0] o_preempt_cnt,
  output logic            o_starved
);

  localparam logic [1:0]  MY_ACC    = acc_code(MOD_ID);
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);

  req_state_t      r_state;
  logic [LENW-1:0] r_rem;
  logic [LENW-1:0] r_pend_len;
  logic            r_pend_valid;
  logic            r_req, r_done, r_busy, r_granted, r_job_done, r_start_ready, r_starved;

  logic            w_g, w_accept, w_preempt, w_wait_inc, w_wait_clr;
  logic [LENW-1:0] w_start_len;
  logic [15:0]     w_wait_cnt;

  assign w_g         = (i_accmodule == MY_ACC);
  assign w_accept    = i_start && r_start_ready;
  assign w_start_len = (i_job_len == '0) ? LENW'(1) : i_job_len;
  assign w_preempt   = (r_state == S_XFER) && !w_g && (r_rem > LENW'(1));
  assign w_wait_inc  = (r_state == S_REQ) && !w_g;
  assign w_wait_clr  = w_g || (r_state != S_REQ);

  sat_counter #(.W(16)) u_wait_cnt (
    .i_clk (i_clk),
    .i_rst (i_reset),
    .i_inc (w_wait_inc),
    .i_clr (w_wait_clr),
    .o_cnt (w_wait_cnt)
  );

  sat_counter #(.W(CNTW)) u_preempt_cnt (
    .i_clk (i_clk),
    .i_rst (i_reset),
    .i_inc (w_preempt),
    .i_clr (1'b0),
    .o_cnt (o_preempt_cnt)
  );

  // FSM, job slots and registered handshake outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_rem         <= '0;
      r_pend_len    <= '0;
      r_pend_valid  <= 1'b0;
      r_req         <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_granted     <= 1'b0;
      r_job_done    <= 1'b0;
      r_start_ready <= 1'b1;
      r_starved     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_job_done <= 1'b0;
      r_granted  <= 1'b0;
      if (w_wait_inc && (w_wait_cnt >= WAIT_LAST)) begin
        r_starved <= 1'b1;
      end else begin
        r_starved <= r_starved;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rem   <= w_start_len;
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ, S_XFER: begin
          // ready was high, so the pending slot is free to take this job
          if (w_accept) begin
            r_pend_valid  <= 1'b1;
            r_pend_len    <= w_start_len;
            r_start_ready <= 1'b0;
          end else begin
            r_pend_valid <= r_pend_valid;
          end
          if (r_state == S_REQ) begin
            if (w_g) r_state <= S_XFER;
            else     r_state <= S_REQ;
          end else if (w_g) begin
            r_granted <= 1'b1;
            if (r_rem == LENW'(1)) begin
              r_state    <= S_DONE;
              r_req      <= 1'b0;
              r_done     <= 1'b1;
              r_job_done <= 1'b1;
            end else begin
              r_rem <= r_rem - LENW'(1);
            end
          end else if (r_rem > LENW'(1)) begin
            r_state <= S_REQ;
          end else begin
            r_state <= S_XFER;
          end
        end
        S_DONE: begin
          if (r_pend_valid) begin
            r_rem         <= r_pend_len;
            r_pend_valid  <= 1'b0;
            r_state       <= S_REQ;
            r_req         <= 1'b1;
            r_start_ready <= 1'b1;
          end else if (w_accept) begin
            r_rem   <= w_start_len;
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end else begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_start_ready = r_start_ready;
  assign o_req         = r_req;
  assign o_done        = r_done;
  assign o_busy        = r_busy;
  assign o_granted     = r_granted;
  assign o_job_done    = r_job_done;
  assign o_starved     = r_starved;

endmodule

// File: tb/tb_module_requester.sv
// Directed bench for module_requester (MOD_ID=1, WAIT_LIMIT=4) with immediate-assertion checks.
module tb_module_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] job_len;
  logic [1:0] acc;
  logic       start_ready, req, done, busy, granted, job_done, starved;
  logic [7:0] preempt_cnt;

  int errors = 0;
  int checks = 0;
  int dones, jdones;

  always #5 clk = ~clk;

  module_requester #(.MOD_ID(1), .LENW(8), .WAIT_LIMIT(4), .CNTW(8)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_job_len     (job_len),
    .o_start_ready (start_ready),
    .i_accmodule   (acc),
    .o_req         (req),
    .o_done        (done),
    .o_busy        (busy),
    .o_granted     (granted),
    .o_job_done    (job_done),
    .o_preempt_cnt (preempt_cnt),
    .o_starved     (starved)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; job_len = 8'd0; acc = 2'd0;
    tick(); tick();
    chk("rst_req", req, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_preempt", preempt_cnt, 0);
    chk("rst_starved", starved, 0);
    rst = 1'b0;
    tick();
    chk("idle_req", req, 0);
    chk("idle_ready", start_ready, 1);

    // single job of 3 beats, grant held
    start = 1'b1; job_len = 8'd3; acc = 2'd2;
    tick(); start = 1'b0;
    chk("j1_req_rise", req, 1);
    chk("j1_busy", busy, 1);
    tick();
    chk("j1_granted_req", granted, 0);
    tick(); chk("j1_beat1", granted, 1);
    tick(); chk("j1_beat2", granted, 1); chk("j1_nodone", done, 0);
    tick();
    chk("j1_beat3", granted, 1);
    chk("j1_done", done, 1);
    chk("j1_jobdone", job_done, 1);
    chk("j1_req_low", req, 0);
    tick();
    chk("j1_done_end", done, 0);
    chk("j1_idle", busy, 0);
    chk("j1_granted_end", granted, 0);

    // 4-beat job, preempted after 2 beats
    start = 1'b1; job_len = 8'd4; acc = 2'd2;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    acc = 2'd1;
    tick();
    chk("j2_preempt_cnt", preempt_cnt, 1);
    chk("j2_req_held", req, 1);
    chk("j2_no_beat", granted, 0);
    tick(); tick();
    acc = 2'd2;
    tick(); chk("j2_req_back", req, 1);
    tick(); chk("j2_beat3", granted, 1); chk("j2_nodone", done, 0);
    tick(); chk("j2_done", done, 1); chk("j2_starved", starved, 0);
    tick(); chk("j2_idle", busy, 0);

    // job_len 0 runs as a single beat
    start = 1'b1; job_len = 8'd0;
    tick(); start = 1'b0;
    tick(); chk("len0_nodone", done, 0);
    tick(); chk("len0_done", done, 1);
    tick(); chk("len0_idle", busy, 0);

    // back-to-back: two accepted, third ignored
    start = 1'b1; job_len = 8'd2;
    tick(); job_len = 8'd1;
    tick(); chk("b2b_ready_low", start_ready, 0);
    job_len = 8'd5;
    tick(); chk("b2b_ready_still_low", start_ready, 0);
    start = 1'b0;
    dones = 0; jdones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) dones++;
      if (job_done) jdones++;
      chk("b2b_req_done_excl", req && done, 0);
    end
    chk("b2b_done_count", dones, 2);
    chk("b2b_jobdone_count", jdones, 2);
    chk("b2b_idle", busy, 0);
    chk("b2b_ready_end", start_ready, 1);

    // starvation with no grant
    acc = 2'd0; start = 1'b1; job_len = 8'd1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("starve_early", starved, 0);
    tick();
    chk("starve_set", starved, 1);
    acc = 2'd2;
    tick(); tick();
    chk("starve_done", done, 1);
    chk("starve_sticky", starved, 1);
    tick();

    // reset in the middle of a transfer
    start = 1'b1; job_len = 8'd5;
    tick(); start = 1'b0;
    tick(); tick();
    chk("mid_granted", granted, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_ready", start_ready, 1);
    chk("mid_rst_preempt", preempt_cnt, 0);
    chk("mid_rst_starved", starved, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_done", done, 0);
      chk("mid_idle", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
